// File: rtl/store_buffer.sv
// Posted-write store buffer between MEM and the single-port DataMemory.
// Loads own the port unless they hit a pending store or the buffer is full.
module store_buffer #(
  parameter int         DEPTH = 4,
  parameter int         PTR_W = 2,
  parameter logic [1:0] W4    = 2'b10,
  parameter logic [1:0] W2    = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_width,
  input  logic [31:0]      st_pc,
  output logic             st_misalign,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [1:0]       ld_width,
  output logic             ld_stall,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [1:0]       dm_width,
  output logic [31:0]      dm_pc,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
    logic [31:0] pc;
  } entry_t;

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;

  logic mis, full, hit, enq, drain, ld_own;

  always_comb begin
    mis = ((st_width == W4) & (st_addr[1:0] != 2'b00)) |
          ((st_width == W2) & st_addr[0]);
    full = (count_q == FULL_CNT);
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && mem_q[i].addr[31:2] == ld_addr[31:2])
        hit = 1'b1;
    end
    hit = hit & ld_valid;

    st_ready    = reset | !full;
    st_misalign = st_valid & mis;
    empty       = reset | (count_q == '0);
    count       = count_q;
    ld_stall    = !reset & ld_valid & (hit | full);

    ld_own = !reset & ld_valid & !ld_stall;
    drain  = !reset & !ld_own & (count_q != '0);
    enq    = !reset & st_valid & !full & !mis;

    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;
    dm_width = '0;
    dm_pc    = '0;
    if (ld_own) begin
      dm_addr  = ld_addr;
      dm_width = ld_width;
    end else if (drain) begin
      dm_we    = 1'b1;
      dm_addr  = mem_q[head_q].addr;
      dm_wdata = mem_q[head_q].data;
      dm_width = mem_q[head_q].width;
      dm_pc    = mem_q[head_q].pc;
    end

    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (enq) begin
      mem_d[tail_q]   = '{st_addr, st_data, st_width, st_pc};
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, drain};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain latency, load stalls,
// misalign rejection, pointer wrap and reset discard.
module tb_store_buffer;

  localparam logic [1:0] W4 = 2'b10;
  localparam logic [1:0] W2 = 2'b01;
  localparam logic [1:0] W1 = 2'b00;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_ready, st_misalign;
  logic [31:0] st_addr, st_data, st_pc;
  logic [1:0]  st_width;
  logic        ld_valid, ld_stall;
  logic [31:0] ld_addr;
  logic [1:0]  ld_width;
  logic        dm_we, empty;
  logic [31:0] dm_addr, dm_wdata, dm_pc;
  logic [1:0]  dm_width;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .st_width(st_width), .st_pc(st_pc),
    .st_misalign(st_misalign),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_width(ld_width), .ld_stall(ld_stall),
    .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_width(dm_width),
    .dm_pc(dm_pc), .empty(empty), .count(count)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] w);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_width = w;
    st_pc    = 32'h1000 + a;
  endtask

  task automatic st_off();
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_width = W4;
    st_pc    = '0;
  endtask

  task automatic ld(input logic v, input logic [31:0] a,
                    input logic [1:0] w);
    ld_valid = v;
    ld_addr  = a;
    ld_width = w;
  endtask

  logic [31:0] exp_a [5];
  logic [31:0] exp_d [5];

  initial begin
    reset = 1'b1;
    st_off();
    ld(1'b1, 32'h40, W4);
    #2;
    check("rst_dm_we", dm_we, 0);
    check("rst_ld_stall", ld_stall, 0);
    check("rst_st_ready", st_ready, 1);
    check("rst_empty", empty, 1);
    tick();
    reset = 1'b0;
    ld(1'b0, 0, W4);
    #1;
    check("rst_count", count, 0);

    // sw then drain next cycle
    st(32'h100, 32'h11223344, W4);
    #1;
    check("t1_ready", st_ready, 1);
    check("t1_mis", st_misalign, 0);
    check("t1_we0", dm_we, 0);
    tick();
    st_off();
    #1;
    check("t1_count", count, 1);
    check("t1_we", dm_we, 1);
    check("t1_addr", dm_addr, 32'h100);
    check("t1_wdata", dm_wdata, 32'h11223344);
    check("t1_width", dm_width, W4);
    check("t1_pc", dm_pc, 32'h1100);
    tick();
    #1;
    check("t1_empty", empty, 1);
    check("t1_we_after", dm_we, 0);

    // loads hold the port until the buffer fills
    ld(1'b1, 32'h200, W4);
    for (int i = 0; i < 4; i++) begin
      st(32'(i * 4), 32'hA0 + 32'(i), W4);
      #1;
      check("t2_ld_own", dm_addr, 32'h200);
      check("t2_no_drain", dm_we, 0);
      tick();
    end
    st_off();
    #1;
    check("t2_count4", count, 4);
    check("t2_ready0", st_ready, 0);
    check("t2_stall_full", ld_stall, 1);
    check("t2_drain_we", dm_we, 1);
    check("t2_drain_addr", dm_addr, 32'h0);
    tick();
    #1;
    check("t2_count3", count, 3);
    check("t2_stall0", ld_stall, 0);
    check("t2_ld_addr", dm_addr, 32'h200);
    ld(1'b0, 0, W4);
    for (int i = 1; i < 4; i++) begin
      #1;
      check("t2_order", dm_addr, 32'(i * 4));
      check("t2_odata", dm_wdata, 32'hA0 + 32'(i));
      tick();
    end
    #1;
    check("t2_empty", empty, 1);

    // load hitting a pending byte store
    st(32'h103, 32'h000000AB, W1);
    tick();
    st_off();
    ld(1'b1, 32'h100, W4);
    #1;
    check("t3_stall", ld_stall, 1);
    check("t3_we", dm_we, 1);
    check("t3_addr", dm_addr, 32'h103);
    check("t3_width", dm_width, W1);
    check("t3_wdata", dm_wdata, 32'hAB);
    tick();
    #1;
    check("t3_unstall", ld_stall, 0);
    check("t3_ld_we", dm_we, 0);
    check("t3_ld_addr", dm_addr, 32'h100);
    check("t3_ld_width", dm_width, W4);
    ld(1'b0, 0, W4);

    // misaligned stores are rejected
    st(32'h102, 32'h55, W4);
    #1;
    check("t4_mis_w", st_misalign, 1);
    check("t4_we_w", dm_we, 0);
    tick();
    st(32'h101, 32'h66, W2);
    #1;
    check("t4_mis_h", st_misalign, 1);
    check("t4_we_h", dm_we, 0);
    tick();
    st_off();
    #1;
    check("t4_count", count, 0);
    check("t4_we", dm_we, 0);

    // fill with a blocking load, then store+drain, with wrap
    for (int i = 0; i < 5; i++) begin
      exp_a[i] = 32'h10 + 32'(i * 4);
      exp_d[i] = 32'hD0 + 32'(i);
    end
    ld(1'b1, 32'h300, W4);
    for (int i = 0; i < 4; i++) begin
      st(exp_a[i], exp_d[i], W4);
      tick();
    end
    st(exp_a[4], exp_d[4], W4);
    #1;
    check("t5_full_rdy", st_ready, 0);
    check("t5_full_drain", dm_addr, exp_a[0]);
    tick();
    ld(1'b0, 0, W4);
    #1;
    check("t5_cnt3", count, 3);
    check("t5_rdy", st_ready, 1);
    check("t5_both_addr", dm_addr, exp_a[1]);
    tick();
    st_off();
    #1;
    check("t5_cnt_same", count, 3);
    for (int i = 2; i < 5; i++) begin
      #1;
      check("t5_wrap_addr", dm_addr, exp_a[i]);
      check("t5_wrap_data", dm_wdata, exp_d[i]);
      tick();
    end
    #1;
    check("t5_empty", empty, 1);

    // reset discards pending stores
    ld(1'b1, 32'h500, W4);
    for (int i = 0; i < 3; i++) begin
      st(32'h40 + 32'(i * 4), 32'hE0, W4);
      tick();
    end
    st_off();
    #1;
    check("t6_cnt3", count, 3);
    reset = 1'b1;
    #1;
    check("t6_rst_we", dm_we, 0);
    check("t6_rst_stall", ld_stall, 0);
    tick();
    reset = 1'b0;
    ld(1'b0, 0, W4);
    #1;
    check("t6_count", count, 0);
    check("t6_empty", empty, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_no_we", dm_we, 0);
      tick();
    end
    ld(1'b1, 32'h44, W4);
    #1;
    check("t6_no_hit", ld_stall, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
